alu_result_capture: RTL and testbench
=====================================

ALU_RESULT_CAPTURE -- requirements
Module: alu_result_capture

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port on  input  1  ALU enable; capture ignored when 0.
REQ-005 SHALL have port cap_valid  input  1  ALU result present this cycle.
REQ-006 SHALL have port out_sel  input  7  one-hot ALU operation select accompanying the result.
REQ-007 SHALL have port result  input  8  ALU output value.
REQ-008 SHALL have port curr_state  input  2  ALU current state, tagged when STATE_TAG_EN is defined.
REQ-009 SHALL have port cap_ready  output  1  high when the FIFO is not full.
REQ-010 SHALL have port rd_en  input  1  pop request from the reader.
REQ-011 SHALL have port rd_data  output  13  head entry {state[1:0], op[2:0], result[7:0]}.
REQ-012 SHALL have port rd_empty  output  1  FIFO empty.
REQ-013 SHALL have port count  output  5  current occupancy.
REQ-014 SHALL have port overflow  output  1  sticky: capture attempted while full.
REQ-015 SHALL have port sel_err_cnt  output  8  count of captures with illegal out_sel.

Function
REQ-016 SHALL accept a capture when on=1, cap_valid=1 and out_sel is exactly one-hot.
REQ-017 SHALL encode out_sel bit6..bit0 to op 0..6 (bit6 -> 0, bit0 -> 6).
REQ-018 SHALL drop a capture with zero or multi-hot out_sel, increment sel_err_cnt, and saturate it at 255.
REQ-019 SHALL write an accepted capture to the tail at the next rising edge; count rises one cycle after acceptance.
REQ-020 SHALL present the head on rd_data combinationally (first-word fall-through, zero read latency).
REQ-021 SHALL pop the head on the rising edge where rd_en=1 and rd_empty=0; rd_en while empty is ignored.
REQ-022 SHALL, on a legal capture while full, drop the data, set overflow, and leave the FIFO unchanged.
REQ-023 SHALL allow a simultaneous push and pop when full: pop succeeds, push is written, count stays DEPTH, and overflow is not set.
REQ-024 SHALL allow a simultaneous push and pop when empty: push only, count becomes 1.
REQ-025 SHALL wrap the read and write pointers modulo DEPTH.
REQ-026 SHALL keep overflow set until reset.
REQ-027 SHALL drive cap_ready = (count != DEPTH) from registered state only.

Reset
REQ-028 SHALL, on rst=0, immediately clear the pointers, set count=0, rd_empty=1, cap_ready=1, overflow=0, sel_err_cnt=0, and rd_data=0, independent of clk.
REQ-029 SHALL discard all stored entries when reset is asserted mid-operation; FIFO contents need not be cleared.
REQ-030 SHALL ignore cap_valid and rd_en on the first rising edge after rst deasserts only if rst is still low at that edge.

Configuration
REQ-031 SHALL use macro ALU_CAP_STATE_TAG_EN.
REQ-032 SHALL, when ALU_CAP_STATE_TAG_EN is defined, store curr_state in rd_data[12:11].
REQ-033 SHALL, when ALU_CAP_STATE_TAG_EN is undefined, drive rd_data[12:11] to 2'b00 and omit their storage.

Structure
REQ-034 SHALL take the entry width, the op-code constants OP_SEL6..OP_SEL0 and the default DEPTH from the shared package alu_cap_pkg.
REQ-035 SHALL implement the one-hot to op encoding plus legality check in sub-module onehot7_enc (in out_sel[6:0]; out op[2:0], legal).

Verification
REQ-036 SHALL test basic capture: with on=1, out_sel=7'b1000000 and result=8'h71, pulse cap_valid; the bench SHALL see count=1 and rd_data[10:0]={3'd0,8'h71}, then pop with rd_en and see rd_empty=1.
REQ-037 SHALL test illegal selects: out_sel=7'b0000000 then 7'b1000001, each with cap_valid; the bench SHALL see sel_err_cnt=2 and count=0.
REQ-038 SHALL test the full and overflow boundary: push 5 legal captures with DEPTH=4; the bench SHALL see cap_ready=0 after the 4th, overflow=1 after the 5th, and pops returning the first 4 values in order.
REQ-039 SHALL test simultaneous push and pop when full: the bench SHALL see count stay 4, overflow=0, and the new value emerge after 3 further pops.
REQ-040 SHALL test reset mid-operation: assert rst=0 between clock edges with count=3; the bench SHALL see count=0, rd_empty=1 and overflow=0 immediately, and sel_err_cnt=0.
REQ-041 SHALL test the state tag: with ALU_CAP_STATE_TAG_EN defined and curr_state=2'b10, the bench SHALL see rd_data[12:11]=2'b10; with the macro undefined it SHALL see 2'b00.

Source files
------------

// File: rtl/alu_cap_pkg.sv
// Shared constants for the ALU result capture FIFO.
// Entry layout is {state[1:0], op[2:0], result[7:0]}.
package alu_cap_pkg;

   localparam int ENTRY_W   = 13;
   localparam int DEF_DEPTH = 4;

   localparam logic [2:0] OP_SEL6 = 3'd0;
   localparam logic [2:0] OP_SEL5 = 3'd1;
   localparam logic [2:0] OP_SEL4 = 3'd2;
   localparam logic [2:0] OP_SEL3 = 3'd3;
   localparam logic [2:0] OP_SEL2 = 3'd4;
   localparam logic [2:0] OP_SEL1 = 3'd5;
   localparam logic [2:0] OP_SEL0 = 3'd6;

endpackage

// File: rtl/alu_result_capture_if.sv
// Capture and read-side bus of the ALU result capture FIFO.
// master = ALU/reader side, slave = FIFO.
interface alu_result_capture_if;

   logic        on;
   logic        cap_valid;
   logic [6:0]  out_sel;
   logic [7:0]  result;
   logic [1:0]  curr_state;
   logic        cap_ready;
   logic        rd_en;
   logic [12:0] rd_data;
   logic        rd_empty;

   modport master (
      output on, cap_valid, out_sel, result, curr_state, rd_en,
      input  cap_ready, rd_data, rd_empty
   );

   modport slave (
      input  on, cap_valid, out_sel, result, curr_state, rd_en,
      output cap_ready, rd_data, rd_empty
   );

endinterface

// File: rtl/onehot7_enc.sv
// One-hot select encoder with legality check.
// bit6 maps to op 0, bit0 maps to op 6.
module onehot7_enc
   import alu_cap_pkg::*;
(
   input  logic [6:0] out_sel,
   output logic [2:0] op,
   output logic       legal
);

   always_comb begin
      op = OP_SEL6;
      case (1'b1)
         out_sel[6]: op = OP_SEL6;
         out_sel[5]: op = OP_SEL5;
         out_sel[4]: op = OP_SEL4;
         out_sel[3]: op = OP_SEL3;
         out_sel[2]: op = OP_SEL2;
         out_sel[1]: op = OP_SEL1;
         out_sel[0]: op = OP_SEL0;
         default:    op = OP_SEL6;
      endcase
   end

   assign legal = (out_sel != 7'd0) &&
                  ((out_sel & (out_sel - 7'd1)) == 7'd0);

endmodule

// File: rtl/alu_result_capture.sv
// First-word fall-through capture FIFO for ALU results.
// Optional state tag storage: define ALU_CAP_STATE_TAG_EN.
module alu_result_capture
   import alu_cap_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_result_capture_if.slave  bus,
   output logic [4:0]           count,
   output logic                 overflow,
   output logic [7:0]           sel_err_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [4:0] FULL_CNT = 5'(DEPTH);
`ifdef ALU_CAP_STATE_TAG_EN
   localparam int SW = ENTRY_W;
`else
   localparam int SW = ENTRY_W - 2;
`endif

   logic [SW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [2:0]    op;
   logic          legal;
   logic          cap;
   logic          full;
   logic          empty;
   logic          pop;
   logic          push;
   logic [SW-1:0] wdata;
   logic [SW-1:0] head;

   onehot7_enc u_enc (
      .out_sel (bus.out_sel),
      .op      (op),
      .legal   (legal)
   );

   assign cap   = bus.on & bus.cap_valid;
   assign full  = (count == FULL_CNT);
   assign empty = (count == 5'd0);
   assign pop   = bus.rd_en & ~empty;
   // a pop in the same cycle frees the slot, so full does not block
   assign push  = cap & legal & (~full | pop);
   assign head  = mem[rptr];

`ifdef ALU_CAP_STATE_TAG_EN
   assign wdata       = {bus.curr_state, op, bus.result};
   assign bus.rd_data = empty ? 13'd0 : head;
`else
   logic unused_state;
   assign unused_state = ^bus.curr_state;
   assign wdata        = {op, bus.result};
   assign bus.rd_data  = empty ? 13'd0 : {2'b00, head};
`endif

   assign bus.rd_empty  = empty;
   assign bus.cap_ready = ~full;

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr        <= '0;
         rptr        <= '0;
         count       <= 5'd0;
         overflow    <= 1'b0;
         sel_err_cnt <= 8'd0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 5'd1;
         else if (pop && !push) count <= count - 5'd1;
         if (cap && legal && full && !pop) overflow <= 1'b1;
         if (cap && !legal && sel_err_cnt != 8'hFF)
            sel_err_cnt <= sel_err_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed table-driven bench for alu_result_capture.
// Tag expectations follow ALU_CAP_STATE_TAG_EN.
module tb_alu_result_capture;

   logic       clk;
   logic       rst;
   logic [4:0] count;
   logic       overflow;
   logic [7:0] sel_err_cnt;
   int         n_cmp;
   int         n_bad;

`ifdef ALU_CAP_STATE_TAG_EN
   localparam logic [1:0] TAG = 2'b10;
`else
   localparam logic [1:0] TAG = 2'b00;
`endif

   alu_result_capture_if bus ();

   alu_result_capture #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus.slave),
      .count       (count),
      .overflow    (overflow),
      .sel_err_cnt (sel_err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        on;
      logic        cv;
      logic [6:0]  sel;
      logic [7:0]  res;
      logic        rd;
      logic [4:0]  e_cnt;
      logic        e_emp;
      logic        e_rdy;
      logic [10:0] e_dat;
      logic [7:0]  e_err;
      logic        e_ovf;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic o, input logic cv, input logic [6:0] s,
                        input logic [7:0] r, input logic rd);
      @(negedge clk);
      bus.on = o; bus.cap_valid = cv; bus.out_sel = s;
      bus.result = r; bus.rd_en = rd;
      @(posedge clk);
      #1;
      bus.cap_valid = 1'b0; bus.rd_en = 1'b0;
   endtask

   function automatic logic [12:0] ent(input logic [10:0] d);
      return {TAG, d};
   endfunction

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b0;
      bus.on = 1'b0; bus.cap_valid = 1'b0; bus.out_sel = 7'd0;
      bus.result = 8'd0; bus.curr_state = 2'b10; bus.rd_en = 1'b0;

      tbl[0]  = '{1,1,7'h40,8'h71,0, 1,0,1,11'h071,2'd0,0};
      tbl[1]  = '{1,0,7'h00,8'h00,1, 0,1,1,11'h000,2'd0,0};
      tbl[2]  = '{1,0,7'h00,8'h00,1, 0,1,1,11'h000,2'd0,0};
      tbl[3]  = '{1,1,7'h00,8'h11,0, 0,1,1,11'h000,8'd1,0};
      tbl[4]  = '{1,1,7'h41,8'h22,0, 0,1,1,11'h000,8'd2,0};
      tbl[5]  = '{0,1,7'h01,8'h55,0, 0,1,1,11'h000,8'd2,0};
      tbl[6]  = '{1,1,7'h01,8'hA1,0, 1,0,1,11'h6A1,8'd2,0};
      tbl[7]  = '{1,1,7'h10,8'hB2,0, 2,0,1,11'h6A1,8'd2,0};
      tbl[8]  = '{1,1,7'h04,8'hC3,0, 3,0,1,11'h6A1,8'd2,0};
      tbl[9]  = '{1,1,7'h20,8'hD4,0, 4,0,0,11'h6A1,8'd2,0};
      tbl[10] = '{1,1,7'h02,8'hE5,0, 4,0,0,11'h6A1,8'd2,1};
      tbl[11] = '{1,0,7'h00,8'h00,1, 3,0,1,11'h2B2,8'd2,1};
      tbl[12] = '{1,0,7'h00,8'h00,1, 2,0,1,11'h4C3,8'd2,1};
      tbl[13] = '{1,0,7'h00,8'h00,1, 1,0,1,11'h1D4,8'd2,1};
      tbl[14] = '{1,0,7'h00,8'h00,1, 0,1,1,11'h000,8'd2,1};
      tbl[15] = '{1,1,7'h40,8'hF0,1, 1,0,1,11'h0F0,8'd2,1};
      tbl[16] = '{1,1,7'h08,8'h33,0, 2,0,1,11'h0F0,8'd2,1};
      tbl[17] = '{1,1,7'h01,8'h44,0, 3,0,1,11'h0F0,8'd2,1};

      #2;
      chk("rst.count", count, 0);
      chk("rst.empty", bus.rd_empty, 1);
      chk("rst.ready", bus.cap_ready, 1);
      chk("rst.ovf", overflow, 0);
      chk("rst.selerr", sel_err_cnt, 0);
      chk("rst.data", bus.rd_data, 0);
      @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 18; i++) begin
         drive(tbl[i].on, tbl[i].cv, tbl[i].sel, tbl[i].res, tbl[i].rd);
         chk($sformatf("v%0d.count", i), count, tbl[i].e_cnt);
         chk($sformatf("v%0d.empty", i), bus.rd_empty, tbl[i].e_emp);
         chk($sformatf("v%0d.ready", i), bus.cap_ready, tbl[i].e_rdy);
         chk($sformatf("v%0d.data", i), bus.rd_data,
             tbl[i].e_emp ? 13'd0 : ent(tbl[i].e_dat));
         chk($sformatf("v%0d.selerr", i), sel_err_cnt, tbl[i].e_err);
         chk($sformatf("v%0d.ovf", i), overflow, tbl[i].e_ovf);
      end

      // reset between edges with three entries held
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid.count", count, 0);
      chk("mid.empty", bus.rd_empty, 1);
      chk("mid.ovf", overflow, 0);
      chk("mid.selerr", sel_err_cnt, 0);
      chk("mid.data", bus.rd_data, 0);
      chk("mid.ready", bus.cap_ready, 1);
      @(negedge clk);
      rst = 1'b1;

      drive(1, 1, 7'h40, 8'h0A, 0);
      drive(1, 1, 7'h20, 8'h1B, 0);
      drive(1, 1, 7'h10, 8'h2C, 0);
      drive(1, 1, 7'h08, 8'h3D, 0);
      chk("full.ready", bus.cap_ready, 0);
      drive(1, 1, 7'h04, 8'h4E, 1);
      chk("pp.count", count, 4);
      chk("pp.ovf", overflow, 0);
      chk("pp.head", bus.rd_data, ent(11'h11B));
      drive(1, 0, 7'h00, 8'h00, 1);
      drive(1, 0, 7'h00, 8'h00, 1);
      drive(1, 0, 7'h00, 8'h00, 1);
      chk("pp.new", bus.rd_data, ent(11'h44E));
      chk("pp.count1", count, 1);

      for (int i = 0; i < 260; i++) drive(1, 1, 7'h03, 8'h00, 0);
      chk("sat.selerr", sel_err_cnt, 255);
      chk("sat.count", count, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
